// File: rtl/mca_downsample_sequencer.sv
// -----------------------------------------------------------------------------
// mca_downsample_sequencer
//
// Decimation controller for the hierarchical FIR adder of the CBADC estimator.
// It counts accepted control-vector beats and shifts the external S history on
// each one. After the first K beats it issues one adder start every DOWNSAMPLE
// beats. It captures the adder result ADDER_LATENCY cycles after each start and
// queues it in a small output FIFO that the consumer drains with valid/ready.
//
// Ports
//   clk            rising-edge clock
//   reset          synchronous, active-high; clears all state and flushes FIFO
//   enable         gates s_valid; an in-flight adder computation still finishes
//   s_valid        control vector present this cycle
//   s_shift_en     s_valid & enable (combinational), shifts the S register
//   s_snapshot     one-cycle pulse with adder_start, freezes the adder's S copy
//   adder_start    one-cycle registered start pulse to the adder
//   adder_sample   adder result, valid ADDER_LATENCY cycles after the start
//   sample_data    FIFO head (0 when empty)
//   sample_valid   FIFO not empty
//   sample_ready   consumer accepts the head
//   fill_done      sticky: K vectors accepted since reset
//   overrun        sticky: a result was dropped because the FIFO was full
//   collision      sticky: a start fell due while the adder was busy
//   clear_flags    clears overrun and collision
// -----------------------------------------------------------------------------
module mca_downsample_sequencer #(
    parameter int K                 = 256,
    parameter int N                 = 8,
    parameter int WIDTH_COEFFICIENT = 32,
    parameter int DOWNSAMPLE        = 16,
    parameter int ADDER_LATENCY     = 4,
    parameter int FIFO_DEPTH        = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         s_valid,
    output logic                         s_shift_en,
    output logic                         s_snapshot,
    output logic                         adder_start,
    input  logic [WIDTH_COEFFICIENT-1:0] adder_sample,
    output logic [WIDTH_COEFFICIENT-1:0] sample_data,
    output logic                         sample_valid,
    input  logic                         sample_ready,
    output logic                         fill_done,
    output logic                         overrun,
    output logic                         collision,
    input  logic                         clear_flags
);

    localparam int FILL_W  = $clog2(K + 1);
    localparam int PHASE_W = (DOWNSAMPLE > 1) ? $clog2(DOWNSAMPLE) : 1;
    localparam int LAT_W   = $clog2(ADDER_LATENCY + 1);
    localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam bit PARAMS_OK = (K >= 1) && (N >= 1) && (DOWNSAMPLE >= 1) &&
                               (ADDER_LATENCY >= 1) && (FIFO_DEPTH >= 1);

    // An illegal parameter set elaborates this marker block, which makes the
    // problem visible in the elaborated hierarchy.
    generate
        if (!PARAMS_OK) begin : g_invalid_parameters
        end
    endgenerate

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } adder_state_e;

    // ---------------------------------------------------------------- state
    logic [FILL_W-1:0]  fill_cnt_q,  fill_cnt_d;
    logic               fill_done_q, fill_done_d;
    logic [PHASE_W-1:0] phase_q,     phase_d;
    adder_state_e       state_q,     state_d;
    logic [LAT_W-1:0]   lat_cnt_q,   lat_cnt_d;
    logic               start_q,     start_d;
    logic               overrun_q,   overrun_d;
    logic               collision_q, collision_d;
    logic [PTR_W-1:0]   rd_ptr_q,    rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q,    wr_ptr_d;
    logic [CNT_W-1:0]   count_q,     count_d;
    logic [WIDTH_COEFFICIENT-1:0] fifo_mem [FIFO_DEPTH];

    logic beat;
    logic trigger;
    logic capture;
    logic adder_free_next;
    logic pop;
    logic push_ok;

    // ------------------------------------------------- beat / decimation count
    always_comb begin
        beat        = s_valid & enable;
        fill_cnt_d  = fill_cnt_q;
        fill_done_d = fill_done_q;
        phase_d     = phase_q;
        trigger     = 1'b0;
        if (beat) begin
            if (!fill_done_q) begin
                fill_cnt_d = fill_cnt_q + 1'b1;
                if (fill_cnt_q == FILL_W'(K - 1)) begin
                    fill_done_d = 1'b1;
                    trigger     = 1'b1;
                    phase_d     = '0;
                end
            end else if (phase_q == PHASE_W'(DOWNSAMPLE - 1)) begin
                phase_d = '0;
                trigger = 1'b1;
            end else begin
                phase_d = phase_q + 1'b1;
            end
        end
    end

    // ------------------------------------------------------- adder tracking
    // The start pulse is registered, so the decision to issue it is taken in
    // the trigger cycle from the adder state projected one cycle ahead. The
    // adder counts as free next cycle when it will be idle or will be doing
    // its capture, since a capture and a new start may share a cycle.
    always_comb begin
        capture   = (state_q == ST_BUSY) && (lat_cnt_q == LAT_W'(1));
        state_d   = state_q;
        lat_cnt_d = lat_cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_q) begin
                    state_d   = ST_BUSY;
                    lat_cnt_d = LAT_W'(ADDER_LATENCY);
                end
            end
            ST_BUSY: begin
                if (capture) begin
                    if (start_q) begin
                        lat_cnt_d = LAT_W'(ADDER_LATENCY);
                    end else begin
                        state_d   = ST_IDLE;
                        lat_cnt_d = '0;
                    end
                end else begin
                    lat_cnt_d = lat_cnt_q - 1'b1;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                lat_cnt_d = '0;
            end
        endcase

        adder_free_next = (state_d == ST_IDLE) || (lat_cnt_d == LAT_W'(1));
        start_d         = trigger & adder_free_next;
    end

    // ------------------------------------------------------------ FIFO + flags
    always_comb begin
        pop     = (count_q != '0) & sample_ready;
        // A full FIFO still accepts the push when the head leaves this cycle.
        push_ok = capture & ((count_q != CNT_W'(FIFO_DEPTH)) | pop);

        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        if (push_ok) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (push_ok && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push_ok && pop) begin
            count_d = count_q - 1'b1;
        end

        // A set event wins over a simultaneous clear.
        overrun_d   = (capture & ~push_ok) | (overrun_q & ~clear_flags);
        collision_d = (trigger & ~adder_free_next) | (collision_q & ~clear_flags);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fill_cnt_q  <= '0;
            fill_done_q <= 1'b0;
            phase_q     <= '0;
            state_q     <= ST_IDLE;
            lat_cnt_q   <= '0;
            start_q     <= 1'b0;
            overrun_q   <= 1'b0;
            collision_q <= 1'b0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            fill_cnt_q  <= fill_cnt_d;
            fill_done_q <= fill_done_d;
            phase_q     <= phase_d;
            state_q     <= state_d;
            lat_cnt_q   <= lat_cnt_d;
            start_q     <= start_d;
            overrun_q   <= overrun_d;
            collision_q <= collision_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
        end
    end

    // Storage has no reset; occupancy is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (!reset && push_ok) begin
            fifo_mem[wr_ptr_q] <= adder_sample;
        end
    end

    // ---------------------------------------------------------------- outputs
    assign s_shift_en   = beat;
    assign adder_start  = start_q;
    assign s_snapshot   = start_q;
    assign sample_valid = (count_q != '0);
    assign sample_data  = sample_valid ? fifo_mem[rd_ptr_q] : '0;
    assign fill_done    = fill_done_q;
    assign overrun      = overrun_q;
    assign collision    = collision_q;

endmodule
